// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2
  } state_e;

  localparam int TIMEOUT_DEFAULT = 100000;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request after last_i, with wrap-around.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] last_i,
  output logic [$clog2(N)-1:0] gnt_o,
  output logic                 valid_o
);

  localparam int IW = $clog2(N);

  int           idx;
  logic [IW-1:0] ix;
  logic          found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    ix    = '0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_i) + k) % N;
      ix  = IW'(idx);
      if (!found && req_i[ix]) begin
        gnt_o = ix;
        found = 1'b1;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter, one frame at a time.
// Optional WAIT watchdog enabled by defining UART_TX_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_level,
  input  logic [NUM_REQ*8-1:0]       req_data,
  input  logic                       tx_busy,
  input  logic                       tx_done,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic [NUM_REQ-1:0]         pending,
  output logic                       timeout_err
);

  localparam int IW = $clog2(NUM_REQ);

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   req_q;
  logic [NUM_REQ-1:0]   pend_q, pend_d;
  logic [NUM_REQ-1:0]   rise;
  logic [IW-1:0]        last_q, last_d;
  logic [IW-1:0]        sel_q, sel_d;
  logic [IW-1:0]        gid_q, gid_d;
  logic [7:0]           data_q, data_d;
  logic                 start_q, start_d;
  logic [IW-1:0]        rr_gnt;
  logic                 rr_valid;

`ifdef UART_TX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`else
  logic unused_cfg;
  assign unused_cfg = |TIMEOUT_CYCLES;
`endif

  assign rise = req_level & ~req_q;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr (
    .req_i   (pend_q),
    .last_i  (last_q),
    .gnt_o   (rr_gnt),
    .valid_o (rr_valid)
  );

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q | rise;
    last_d  = last_q;
    sel_d   = sel_q;
    gid_d   = gid_q;
    data_d  = data_q;
    start_d = 1'b0;
`ifdef UART_TX_TIMEOUT_EN
    cnt_d   = '0;
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (rr_valid && !tx_busy) begin
          state_d = LOAD;
          sel_d   = rr_gnt;
        end
      end
      LOAD: begin
        state_d       = WAIT;
        start_d       = 1'b1;
        data_d        = req_data[{sel_q, 3'b000} +: 8];
        gid_d         = sel_q;
        last_d        = sel_q;
        // A fresh edge in this cycle wins over the clear
        pend_d[sel_q] = rise[sel_q];
      end
      WAIT: begin
        if (tx_done) begin
          state_d = IDLE;
`ifdef UART_TX_TIMEOUT_EN
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= '0;
      pend_q  <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      sel_q   <= '0;
      gid_q   <= '0;
      data_q  <= 8'h00;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_level;
      pend_q  <= pend_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      gid_q   <= gid_d;
      data_q  <= data_d;
      start_q <= start_d;
    end
  end

`ifdef UART_TX_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign timeout_err = err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign tx_start = start_q;
  assign tx_data  = data_q;
  assign grant_id = gid_q;
  assign pending  = pend_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter; drives and samples on the falling edge.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
`ifdef UART_TX_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR-1:0] req_level;
  logic [31:0]   req_data;
  logic          tx_busy;
  logic          tx_done;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic [1:0]    grant_id;
  logic [NR-1:0] pending;
  logic          timeout_err;

  int vecs = 0;
  int errs = 0;

  uart_tx_arbiter #(
    .NUM_REQ        (NR),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_level   (req_level),
    .req_data    (req_data),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .grant_id    (grant_id),
    .pending     (pending),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask

  task automatic wait_start(input int max, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      step();
      if (tx_start) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_level = '0;
    req_data  = 32'h44332211;
    tx_busy   = 1'b0;
    tx_done   = 1'b0;
    step();
    step();
    vecs++;
    if (tx_start !== 1'b0 || tx_data !== 8'h00 || grant_id !== 2'd0 ||
        pending !== 4'b0000 || timeout_err !== 1'b0) begin
      errs++;
      $display("FAIL reset: start=%b data=%h gid=%0d pend=%b err=%b want 0/00/0/0000/0",
               tx_start, tx_data, grant_id, pending, timeout_err);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    req_level[2] = 1'b1;
    step();
    vecs++;
    if (pending !== 4'b0100 || tx_start !== 1'b0) begin
      errs++;
      $display("FAIL single_c1: pend=%b start=%b want 0100/0", pending, tx_start);
    end
    step();
    vecs++;
    if (tx_start !== 1'b0) begin
      errs++;
      $display("FAIL single_c2: start=%b want 0", tx_start);
    end
    step();
    vecs++;
    if (tx_start !== 1'b1 || tx_data !== 8'h33 || grant_id !== 2'd2 ||
        pending !== 4'b0000) begin
      errs++;
      $display("FAIL single_c3: start=%b data=%h gid=%0d pend=%b want 1/33/2/0000",
               tx_start, tx_data, grant_id, pending);
    end
    step();
    vecs++;
    if (tx_start !== 1'b0) begin
      errs++;
      $display("FAIL single_pulse: start=%b want 0", tx_start);
    end
    req_level[2] = 1'b0;
    pulse_done();
    step();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_id [3];
    logic [7:0] exp_dt [3];
    logic [3:0] exp_pd [3];
    bit seen;
    int n;
    exp_id = '{2'd0, 2'd1, 2'd3};
    exp_dt = '{8'h11, 8'h22, 8'h44};
    exp_pd = '{4'b1010, 4'b1000, 4'b0000};
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req_level = 4'b1011;
    for (int k = 0; k < 3; k++) begin
      wait_start(12, seen);
      vecs++;
      if (!seen || grant_id !== exp_id[k] || tx_data !== exp_dt[k] ||
          pending !== exp_pd[k]) begin
        errs++;
        $display("FAIL rr_grant%0d: seen=%b gid=%0d data=%h pend=%b want 1/%0d/%h/%b",
                 k, seen, grant_id, tx_data, pending, exp_id[k], exp_dt[k], exp_pd[k]);
      end
      n = 0;
      for (int i = 0; i < 4; i++) begin
        step();
        if (tx_start) n++;
      end
      vecs++;
      if (n != 0 || tx_data !== exp_dt[k] || grant_id !== exp_id[k]) begin
        errs++;
        $display("FAIL rr_hold%0d: extra=%0d data=%h gid=%0d want 0/%h/%0d",
                 k, n, tx_data, grant_id, exp_dt[k], exp_id[k]);
      end
      pulse_done();
    end
    req_level = '0;
    step();
  endtask

  task automatic test_toggle();
    bit seen;
    int n;
    tx_busy = 1'b1;
    for (int t = 0; t < 3; t++) begin
      req_level[1] = 1'b1;
      step();
      step();
      req_level[1] = 1'b0;
      step();
      step();
    end
    vecs++;
    if (pending !== 4'b0010) begin
      errs++;
      $display("FAIL toggle_pend: pend=%b want 0010", pending);
    end
    tx_busy = 1'b0;
    wait_start(6, seen);
    vecs++;
    if (!seen || grant_id !== 2'd1 || tx_data !== 8'h22) begin
      errs++;
      $display("FAIL toggle_grant: seen=%b gid=%0d data=%h want 1/1/22",
               seen, grant_id, tx_data);
    end
    step();
    pulse_done();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tx_start) n++;
    end
    vecs++;
    if (n != 0) begin
      errs++;
      $display("FAIL toggle_frames: extra starts=%0d want 0", n);
    end
  endtask

  task automatic test_busy();
    bit seen;
    int n;
    tx_busy      = 1'b1;
    req_level[0] = 1'b1;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (tx_start) n++;
    end
    vecs++;
    if (n != 0 || pending !== 4'b0001) begin
      errs++;
      $display("FAIL busy_hold: starts=%0d pend=%b want 0/0001", n, pending);
    end
    tx_busy = 1'b0;
    wait_start(6, seen);
    vecs++;
    if (!seen || grant_id !== 2'd0 || tx_data !== 8'h11) begin
      errs++;
      $display("FAIL busy_release: seen=%b gid=%0d data=%h want 1/0/11",
               seen, grant_id, tx_data);
    end
    step();
    pulse_done();
    req_level[0] = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (tx_start) n++;
    end
    vecs++;
    if (n != 0) begin
      errs++;
      $display("FAIL busy_once: extra starts=%0d want 0", n);
    end
  endtask

  task automatic test_set_priority();
    bit seen;
    req_level[3] = 1'b1;
    step();
    req_level[3] = 1'b0;
    step();
    req_level[3] = 1'b1;
    step();
    vecs++;
    if (tx_start !== 1'b1 || grant_id !== 2'd3 || pending !== 4'b1000) begin
      errs++;
      $display("FAIL setprio_load: start=%b gid=%0d pend=%b want 1/3/1000",
               tx_start, grant_id, pending);
    end
    step();
    pulse_done();
    wait_start(6, seen);
    vecs++;
    if (!seen || grant_id !== 2'd3 || pending !== 4'b0000) begin
      errs++;
      $display("FAIL setprio_again: seen=%b gid=%0d pend=%b want 1/3/0000",
               seen, grant_id, pending);
    end
    step();
    pulse_done();
    req_level[3] = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    bit seen;
    int n;
    req_level[2] = 1'b1;
    wait_start(6, seen);
    vecs++;
    if (!seen || grant_id !== 2'd2) begin
      errs++;
      $display("FAIL to_first: seen=%b gid=%0d want 1/2", seen, grant_id);
    end
    req_level[1] = 1'b1;
    n = 0;
`ifdef UART_TX_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      step();
      if (tx_start) n++;
    end
    vecs++;
    if (n != 0 || timeout_err !== 1'b0) begin
      errs++;
      $display("FAIL to_early: starts=%0d err=%b want 0/0", n, timeout_err);
    end
    step();
    vecs++;
    if (timeout_err !== 1'b1) begin
      errs++;
      $display("FAIL to_flag: err=%b want 1", timeout_err);
    end
`else
    for (int i = 0; i < 40; i++) begin
      step();
      if (tx_start) n++;
    end
    vecs++;
    if (n != 0 || timeout_err !== 1'b0) begin
      errs++;
      $display("FAIL to_nowdog: starts=%0d err=%b want 0/0", n, timeout_err);
    end
    pulse_done();
`endif
    wait_start(8, seen);
    vecs++;
    if (!seen || grant_id !== 2'd1 || tx_data !== 8'h22) begin
      errs++;
      $display("FAIL to_next: seen=%b gid=%0d data=%h want 1/1/22",
               seen, grant_id, tx_data);
    end
    step();
    pulse_done();
    req_level = '0;
    step();
    vecs++;
    if (timeout_err !== TO_EN) begin
      errs++;
      $display("FAIL to_sticky: err=%b want %b", timeout_err, TO_EN);
    end
  endtask

  task automatic test_reset_in_wait();
    bit seen;
    int n;
    req_level = 4'b0011;
    wait_start(8, seen);
    vecs++;
    if (!seen) begin
      errs++;
      $display("FAIL rw_start: seen=%b want 1", seen);
    end
    step();
    rst_n        = 1'b0;
    req_level[1] = 1'b0;
    step();
    vecs++;
    if (tx_start !== 1'b0 || tx_data !== 8'h00 || grant_id !== 2'd0 ||
        pending !== 4'b0000 || timeout_err !== 1'b0) begin
      errs++;
      $display("FAIL rw_reset: start=%b data=%h gid=%0d pend=%b err=%b want 0/00/0/0000/0",
               tx_start, tx_data, grant_id, pending, timeout_err);
    end
    rst_n = 1'b1;
    wait_start(8, seen);
    vecs++;
    if (!seen || grant_id !== 2'd0 || tx_data !== 8'h11) begin
      errs++;
      $display("FAIL rw_held: seen=%b gid=%0d data=%h want 1/0/11",
               seen, grant_id, tx_data);
    end
    step();
    pulse_done();
    n = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (tx_start) n++;
    end
    vecs++;
    if (n != 0) begin
      errs++;
      $display("FAIL rw_once: extra starts=%0d want 0", n);
    end
    req_level = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_toggle();
    test_busy();
    test_set_priority();
    test_timeout();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of debounced requesters (range 2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100000, watchdog limit in clk cycles (used only with UART_TX_TIMEOUT_EN).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port req_level  input  NUM_REQ  debounced request levels, already synchronous to clk.
REQ-006 SHALL have port req_data  input  NUM_REQ*8  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-007 SHALL have port tx_busy  input  1  UART transmitter busy.
REQ-008 SHALL have port tx_done  input  1  one-cycle pulse marking end of a frame.
REQ-009 SHALL have port tx_start  output  1  one-cycle start pulse to the transmitter.
REQ-010 SHALL have port tx_data  output  8  byte presented with tx_start and held until tx_done.
REQ-011 SHALL have port grant_id  output  clog2(NUM_REQ)  index of the requester currently served.
REQ-012 SHALL have port pending  output  NUM_REQ  per-requester pending flags.
REQ-013 SHALL have port timeout_err  output  1  sticky watchdog error flag.

Function
REQ-014 SHALL register req_level and set pending[i] on each 0->1 transition of req_level[i]; the edge is seen one cycle after the input rises.
REQ-015 SHALL treat pending as a flag: further edges while pending[i]=1 are dropped and not counted.
REQ-016 SHALL use FSM states IDLE, LOAD, WAIT: IDLE->LOAD when any pending bit is set and tx_busy=0; LOAD->WAIT unconditionally; WAIT->IDLE on tx_done.
REQ-017 SHALL select the requester in IDLE by round-robin, searching from (last_grant+1) mod NUM_REQ upward with wrap-around.
REQ-018 SHALL, in LOAD, assert tx_start for exactly one cycle, drive tx_data from req_data of the granted requester sampled in that cycle, update grant_id, and clear the granted pending bit.
REQ-019 SHALL give set priority when a new edge on the granted requester coincides with its clear in LOAD, leaving pending=1.
REQ-020 SHALL hold tx_data and grant_id stable from LOAD until the next LOAD.
REQ-021 SHALL serve one frame at a time, with at least 1 idle cycle between tx_done and the next tx_start.
REQ-022 SHALL ignore tx_done outside WAIT.

Reset
REQ-023 SHALL, while rst_n=0 at a clk edge, reset FSM=IDLE, pending=0, registered req_level=0, last_grant=NUM_REQ-1 (requester 0 is served first), tx_start=0, tx_data=8'h00, grant_id=0, timeout_err=0, watchdog counter=0.
REQ-024 SHALL, on reset during WAIT, abandon the frame without a further tx_start; a req_level held high through reset produces one request after release.

Configuration
REQ-025 SHALL, with macro UART_TX_TIMEOUT_EN defined, count cycles in WAIT and, on reaching TIMEOUT_CYCLES without tx_done, go to IDLE and set timeout_err until reset.
REQ-026 SHALL, without UART_TX_TIMEOUT_EN, contain no watchdog counter, tie timeout_err to 0, and wait in WAIT indefinitely.

Structure
REQ-027 SHALL take the FSM state enum (IDLE, LOAD, WAIT) and the default TIMEOUT_CYCLES constant from a shared package uart_pkg.
REQ-028 SHALL place round-robin selection in one sub-module rr_arbiter (inputs: request vector, last grant; outputs: grant index, valid).

Verification
REQ-029 SHALL cover: req_level[2] rises with tx_busy=0 -> tx_start exactly 3 cycles after the rise, tx_data=req_data[23:16], grant_id=2, pending[2] cleared.
REQ-030 SHALL cover: req 0,1,3 rise in the same cycle after reset -> grants in order 0,1,3, each after the previous tx_done.
REQ-031 SHALL cover: req_level[1] toggled 3 times while requester 1 waits -> exactly one frame.
REQ-032 SHALL cover: tx_busy=1 held 50 cycles with pending[0]=1 -> no tx_start until tx_busy falls, then one tx_start.
REQ-033 SHALL cover: with UART_TX_TIMEOUT_EN, TIMEOUT_CYCLES=16 and no tx_done -> return to IDLE after 16 WAIT cycles, timeout_err=1, next pending request still served.
REQ-034 SHALL cover: rst_n=0 for 1 cycle during WAIT -> all outputs at reset values on the next cycle and pending=0.
